// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - instruction buffer between fetch and decode
//
// Purpose:
//   Small circular FIFO of (instruction, PC) pairs. The head entry is
//   presented to decode already split into its RISC-V fields, with a flag
//   for opcodes the decode path does not support. A flush squashes all
//   contents and any enqueue or dequeue attempted in the same cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               squash all entries and any same-cycle transfer
//   in_valid/in_ready   fetch-side handshake
//   in_instr, in_pc     fetched instruction word and its PC
//   out_valid/out_ready decode-side handshake
//   out_instr, out_pc   head entry (NOP / PC 0 when empty)
//   out_opcode .. out_funct7  head instruction fields
//   out_illegal         head opcode outside the supported set (informational)
//   count               current occupancy

module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [XLEN-1:0]                in_instr,
  input  logic [XLEN-1:0]                in_pc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [XLEN-1:0]                out_instr,
  output logic [XLEN-1:0]                out_pc,
  output logic [6:0]                     out_opcode,
  output logic [4:0]                     out_rd,
  output logic [2:0]                     out_funct3,
  output logic [4:0]                     out_rs1,
  output logic [4:0]                     out_rs2,
  output logic [6:0]                     out_funct7,
  output logic                           out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // addi x0,x0,0 -- shown on the head outputs whenever the queue is empty
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  logic             enq;
  logic             deq;
  logic             is_full;
  logic             is_empty;

  assign is_full  = (count == CNT_W'(DEPTH));
  assign is_empty = (count == '0);

  // in_ready looks only at occupancy, never at out_ready, so a full queue
  // refuses input even while decode is draining it in the same cycle.
  assign in_ready  = !flush && !is_full;
  assign out_valid = !flush && !is_empty;

  // in_ready / out_valid already fold in flush, so a flush voids both.
  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= NOP_INSTR;
        pc_mem[i]    <= '0;
      end
    end else if (flush) begin
      // Storage is left as-is; count == 0 masks it on the head outputs.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        instr_mem[wr_ptr] <= in_instr;
        pc_mem[wr_ptr]    <= in_pc;
        wr_ptr            <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is read combinationally; no bypass from in_* to out_*.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (!is_empty) begin
      out_instr = instr_mem[rd_ptr];
      out_pc    = pc_mem[rd_ptr];
    end
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_funct3 = out_instr[14:12];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign out_funct7 = out_instr[31:25];

  // Informational only: the queue never stalls or drops on an illegal head.
  // The empty-queue NOP (OP-IMM) is deliberately flagged; out_valid = 0
  // qualifies it.
  always_comb begin
    out_illegal = 1'b1;
    case (out_opcode)
      OP_REG, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: out_illegal = 1'b0;
      default:                                       out_illegal = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - self-checking bench for fetch_decode_queue

module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic        out_illegal;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue of {instr, pc} pairs, oldest first.
  logic [63:0] mq [$];

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_funct3  (out_funct3),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_funct7  (out_funct7),
    .out_illegal (out_illegal),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic supported(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  // Compare every output against what the model says the queue holds.
  task automatic check_all(input string tag);
    logic [31:0] ei;
    logic [31:0] ep;
    int n;
    n  = mq.size();
    ei = (n != 0) ? mq[0][63:32] : NOP;
    ep = (n != 0) ? mq[0][31:0]  : 32'h0;
    chk({tag, ".in_ready"},  32'(in_ready),  32'(!flush && n != DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(!flush && n != 0));
    chk({tag, ".count"},     32'(count),     32'(n));
    chk({tag, ".out_instr"}, out_instr, ei);
    chk({tag, ".out_pc"},    out_pc,    ep);
    chk({tag, ".fields"},
        {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, ei);
    chk({tag, ".illegal"},   32'(out_illegal), 32'(!supported(ei[6:0])));
  endtask

  // Advance one clock: model decisions come from the inputs as they stand
  // before the edge; outputs are sampled 1ns after the edge.
  task automatic tick();
    bit enq, deq;
    enq = in_valid && !flush && (mq.size() != DEPTH);
    deq = out_ready && !flush && (mq.size() != 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back({in_instr, in_pc});
    end
    #1;
  endtask

  initial begin
    int sent;
    int cyc;
    logic [31:0] exp_pc;
    logic [6:0] ops [6];

    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
    ops[3] = 7'b1100011; ops[4] = 7'b1100111; ops[5] = 7'b0010011;

    // Reset held with in_valid = 1
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A0_0093; in_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_instr", out_instr, NOP);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // First edge after release accepts 0x00A00093 @ 0x0
    tick();
    in_valid = 1'b0;
    #1;
    chk("enq0.out_valid", 32'(out_valid), 32'd1);
    chk("enq0.opcode", 32'(out_opcode), 32'b0010011);
    chk("enq0.rd", 32'(out_rd), 32'd1);
    chk("enq0.rs1", 32'(out_rs1), 32'd0);
    chk("enq0.illegal", 32'(out_illegal), 32'd1);
    check_all("enq0");

    // Fill: 0x002081B3 @ 0x4, then keep offering another entry
    in_valid = 1'b1; in_instr = 32'h0020_81B3; in_pc = 32'h4;
    tick();
    in_instr = 32'h0000_0033; in_pc = 32'h8;
    #1;
    chk("full.count", 32'(count), 32'd2);
    chk("full.in_ready", 32'(in_ready), 32'd0);
    check_all("full");

    // Full with dequeue and enqueue offered together: only dequeue happens
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("fulldeq.count", 32'(count), 32'd1);
    chk("fulldeq.head_pc", out_pc, 32'h4);
    chk("fulldeq.in_ready", 32'(in_ready), 32'd1);
    check_all("fulldeq");

    // Drain
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check_all("drain");

    // Stream of 10 entries with out_ready toggling each cycle
    sent = 0; exp_pc = 32'h0; cyc = 0;
    in_instr = 32'h0000_0003; in_pc = 32'h0; in_valid = 1'b1;
    while ((sent < 10 || mq.size() != 0) && cyc < 100) begin
      out_ready = cyc[0];
      in_valid  = (sent < 10);
      in_pc     = 32'(sent) * 4;
      in_instr  = {20'(sent), 5'd2, 7'b0000011};
      #1;
      if (out_valid && out_ready) begin
        chk("stream.order", out_pc, exp_pc);
        exp_pc += 4;
      end
      if (in_valid && in_ready) sent++;
      tick();
      chk("stream.count_max", 32'(count <= 2), 32'd1);
      check_all("stream");
      cyc++;
    end
    chk("stream.all_out", exp_pc, 32'h28);
    in_valid = 1'b0; out_ready = 1'b0;

    // Flush while full with an enqueue offered
    in_valid = 1'b1;
    in_instr = 32'h0000_0023; in_pc = 32'h100; tick();
    in_instr = 32'h0000_0023; in_pc = 32'h104; tick();
    chk("preflush.count", 32'(count), 32'd2);
    flush = 1'b1; in_pc = 32'h108;
    #1;
    chk("flushcyc.in_ready", 32'(in_ready), 32'd0);
    chk("flushcyc.out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("postflush.count", 32'(count), 32'd0);
    chk("postflush.out_valid", 32'(out_valid), 32'd0);
    chk("postflush.in_ready", 32'(in_ready), 32'd1);
    check_all("postflush");

    // beq is supported, opcode 0x7F is not
    in_valid = 1'b1; in_instr = 32'h0000_0063; in_pc = 32'h200;
    tick();
    in_valid = 1'b0;
    #1;
    chk("beq.opcode", 32'(out_opcode), 32'b1100011);
    chk("beq.funct3", 32'(out_funct3), 32'd0);
    chk("beq.illegal", 32'(out_illegal), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_007F; in_pc = 32'h204;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("bad.illegal", 32'(out_illegal), 32'd1);
    check_all("bad");

    // Randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = {$urandom_range(0, 32'h01FF_FFFF) , ops[$urandom_range(0, 5)]};
      in_pc     = $urandom;
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        mq.delete();
        #1;
        chk("midrst.count", 32'(count), 32'd0);
        chk("midrst.out_instr", out_instr, NOP);
        rst_n = 1'b1;
      end
      #1;
      check_all("rand_pre");
      tick();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
